cla_shift_add_multiplier: RTL and testbench

//  Sequential unsigned shift-and-add multiplier built around one shared WIDTH-bit

---
 rtl/cla_shift_add_multiplier_pkg.sv | 15 +
 rtl/cla_shift_add_multiplier_carry_look_ahead.sv | 43 ++++
 rtl/cla_shift_add_multiplier.sv | 111 +++++++++++
 tb/tb_cla_shift_add_multiplier.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state codes and
// the default operand width.
package cla_shift_add_multiplier_pkg;

    localparam int CLA_MUL_WIDTH_DEFAULT = 8;

    // Two-bit state code; ST_BAD is never entered on purpose and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10,
        ST_BAD  = 2'b11
    } state_t;

endpackage

// File: rtl/cla_shift_add_multiplier_carry_look_ahead.sv
// WIDTH-bit carry-look-ahead adder. Every carry is formed directly from the
// generate/propagate terms and the carry-in, so no carry ripples bit to bit.
module carry_look_ahead #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             y,
    output logic [WIDTH-1:0] s,
    output logic             c
);

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Flattened look-ahead: carry[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]y.
    always_comb begin
        logic term;
        logic run_p;
        term     = 1'b0;
        run_p    = 1'b0;
        carry    = '0;
        carry[0] = y;
        for (int i = 0; i < WIDTH; i++) begin
            term  = gen[i];
            run_p = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                term  = term | (run_p & gen[j]);
                run_p = run_p & prop[j];
            end
            term         = term | (run_p & y);
            carry[i + 1] = term;
        end
    end

    assign s = prop ^ carry[WIDTH-1:0];
    assign c = carry[WIDTH];

endmodule

// File: rtl/cla_shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier. One shared carry-look-ahead
// adder is reused once per multiplier bit, so a product takes WIDTH RUN
// cycles. The product {acc_hi, acc_lo} shifts right each step while the
// multiplier bits are consumed from the LSB end of acc_lo.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE and
// out_p holds stable until out_ready is seen. Neither ready depends
// combinationally on the opposite valid.
module cla_shift_add_multiplier
    import cla_shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = CLA_MUL_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [CW-1:0]      count;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               carry_out;
    logic [2*WIDTH-1:0] acc_next;

    // Partial product for this step: the multiplicand gated by the current multiplier bit.
    assign addend = mcand & {WIDTH{acc_lo[0]}};

    carry_look_ahead #(.WIDTH(WIDTH)) u_add (
        .a (acc_hi),
        .b (addend),
        .y (1'b0),
        .s (sum),
        .c (carry_out)
    );

    // Carry-out lands in the MSB of acc_hi; the consumed multiplier bit falls off the bottom.
    assign acc_next  = {carry_out, sum, acc_lo[WIDTH-1:1]};
    assign dbg_state = state;

    // Control FSM, datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_p     <= '0;
            mcand     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            count     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        mcand    <= in_a;
                        acc_hi   <= '0;
                        acc_lo   <= in_b;
                        count    <= COUNT_LAST;
                        state    <= ST_RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    acc_hi <= acc_next[2*WIDTH-1:WIDTH];
                    acc_lo <= acc_next[WIDTH-1:0];
                    if (count == '0) begin
                        state     <= ST_DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        out_p     <= acc_next;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_shift_add_multiplier.sv
// Bench for cla_shift_add_multiplier: directed products with literal
// expectations, backpressure and mid-run reset, a random traffic phase
// checked every cycle against a protocol/arithmetic model, and short
// directed runs on WIDTH=4 and WIDTH=16 instances.
module tb_cla_shift_add_multiplier;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- main DUT (WIDTH=8) ----------------
    logic           in_valid, in_ready, out_valid, out_ready, busy;
    logic [W-1:0]   in_a, in_b;
    logic [2*W-1:0] out_p;
    logic [1:0]     dbg_state;

    cla_shift_add_multiplier #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- WIDTH=4 and WIDTH=16 instances ----------------
    logic        w4_in_valid, w4_in_ready, w4_out_valid, w4_out_ready, w4_busy;
    logic [3:0]  w4_a, w4_b;
    logic [7:0]  w4_out_p;
    logic [1:0]  w4_dbg;
    logic        w16_in_valid, w16_in_ready, w16_out_valid, w16_out_ready, w16_busy;
    logic [15:0] w16_a, w16_b;
    logic [31:0] w16_out_p;
    logic [1:0]  w16_dbg;

    cla_shift_add_multiplier #(.WIDTH(4)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(w4_in_valid), .in_ready(w4_in_ready),
        .in_a(w4_a), .in_b(w4_b), .out_valid(w4_out_valid), .out_ready(w4_out_ready),
        .out_p(w4_out_p), .busy(w4_busy), .dbg_state(w4_dbg)
    );

    cla_shift_add_multiplier #(.WIDTH(16)) dut_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(w16_in_valid), .in_ready(w16_in_ready),
        .in_a(w16_a), .in_b(w16_b), .out_valid(w16_out_valid), .out_ready(w16_out_ready),
        .out_p(w16_out_p), .busy(w16_busy), .dbg_state(w16_dbg)
    );

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model + scoreboard ----------------
    // m_phase: 0 idle, 1 computing, 2 product offered. Products are plain a*b.
    int             m_phase = 0;
    int             m_left  = 0;
    int             m_done  = 0;
    logic [2*W-1:0] m_prod;
    logic [2*W-1:0] exp_q[$];
    logic           cmp_en = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            m_left  = 0;
            exp_q.delete();
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_prod = {8'd0, in_a} * {8'd0, in_b};
                    exp_q.push_back(m_prod);
                    m_left  = W;
                    m_phase = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                default: if (out_ready) begin
                    void'(exp_q.pop_front());
                    m_done++;
                    m_phase = 0;
                end
            endcase
        end
    end

    // Every-cycle comparison of the main DUT against the model.
    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            check("cyc_in_ready", in_ready, m_phase == 0);
            check("cyc_out_valid", out_valid, m_phase == 2);
            check("cyc_busy", busy, m_phase == 1);
            check("cyc_state", dbg_state, m_phase);
            if (m_phase == 2) begin
                if (exp_q.size() > 0) begin
                    check("cyc_out_p", out_p, exp_q[0]);
                end else begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL cyc_out_p: actual=%0d expected=<no pending product>", out_p);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] lit, input int hold);
        int lat;
        lat = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        out_ready = (hold == 0);
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        check("latency", lat, W);
        check("product", out_p, lit);
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                check("bp_out_p", out_p, lit);
                check("bp_in_ready", in_ready, 0);
                check("bp_out_valid", out_valid, 1);
                in_valid = k[0];
                in_a     = 8'hA5;
                in_b     = 8'h5A;
            end
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("ready_after", in_ready, 1);
        check("valid_after", out_valid, 0);
    endtask

    task automatic run_small(input int w, input logic [15:0] a, input logic [15:0] b,
                             input logic [31:0] lit);
        int lat;
        logic [31:0] p;
        lat = 0;
        @(negedge clk);
        if (w == 4) begin
            w4_in_valid = 1'b1;
            w4_a        = a[3:0];
            w4_b        = b[3:0];
        end else begin
            w16_in_valid = 1'b1;
            w16_a        = a;
            w16_b        = b;
        end
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            w4_in_valid  = 1'b0;
            w16_in_valid = 1'b0;
            @(posedge clk);
            #1;
            if ((w == 4 && w4_out_valid) || (w == 16 && w16_out_valid)) begin
                lat = n;
                break;
            end
        end
        p = (w == 4) ? {24'd0, w4_out_p} : w16_out_p;
        check($sformatf("w%0d_latency", w), lat, w);
        check($sformatf("w%0d_product", w), p, lit);
        @(posedge clk);
        #1;
        check($sformatf("w%0d_ready_after", w), (w == 4) ? w4_in_ready : w16_in_ready, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        int cyc;
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        w4_in_valid = 1'b0; w4_a = '0; w4_b = '0; w4_out_ready = 1'b1;
        w16_in_valid = 1'b0; w16_a = '0; w16_b = '0; w16_out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_p", out_p, 0);
        check("rst_state", dbg_state, 0);
        @(negedge clk);
        #1;
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Directed products with literal expectations.
        run_op(8'd13, 8'd11, 16'd143, 0);
        run_op(8'd255, 8'd255, 16'hFE01, 0);
        run_op(8'd0, 8'd200, 16'd0, 0);
        run_op(8'd200, 8'd0, 16'd0, 0);
        run_op(8'd1, 8'd1, 16'd1, 0);
        run_op(8'd6, 8'd7, 16'd42, 5);
        run_op(8'd128, 8'd2, 16'd256, 2);

        // Reset while computing: accept, four RUN steps, then abort.
        @(negedge clk);
        in_valid = 1'b1; in_a = 8'd100; in_b = 8'd77; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_p", out_p, 0);
        check("abort_busy", busy, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        run_op(8'd7, 8'd9, 16'd63, 0);

        // Random traffic with random backpressure, checked every cycle.
        base = m_done;
        cyc  = 0;
        while ((m_done - base) < 1000 && cyc < 40000) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 5))
                0:       in_a = 8'd0;
                1:       in_a = 8'd255;
                default: in_a = 8'($urandom_range(0, 255));
            endcase
            case ($urandom_range(0, 5))
                0:       in_b = 8'd0;
                1:       in_b = 8'd255;
                default: in_b = 8'($urandom_range(0, 255));
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            cyc++;
        end
        check("random_ops_done", (m_done - base) >= 1000, 1);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (W + 4) @(negedge clk);

        // Other widths.
        run_small(4, 16'd15, 16'd15, 32'd225);
        run_small(4, 16'd9, 16'd7, 32'd63);
        run_small(16, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        run_small(16, 16'd1234, 16'd5678, 32'd7006652);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
